serial_alu: RTL and testbench

- Parametrised, bit-serial successor to the team's 1-bit gate-level arithmetic cell (full add, full subtract with borrow, AND, OR).
- Processes two WIDTH-bit operands LSB-first, one bit per clock, through a single 1-bit cell, with carry or borrow held in a flop between bits.
- Sits between a register file and writeback. Uses a start/busy/done handshake.
- Trades latency for area: one cell instead of WIDTH cells.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_bit_cell.sv | 37 +++
 rtl/serial_alu.sv | 145 ++++++++++++++
 tb/tb_serial_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: operation codes and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Carry/borrow only propagates between bits for the arithmetic ops.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit arithmetic/logic cell: full add, full subtract with borrow, AND, OR, XOR.
// Reserved op codes produce r=0 and c_out=0.
module alu_bit_cell
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [2:0] op,
    output logic       r,
    output logic       c_out
);

    // Per-bit result and carry/borrow out for the selected operation.
    always_comb begin
        r     = 1'b0;
        c_out = 1'b0;
        case (op)
            OP_ADD: begin
                r     = a ^ b ^ c;
                c_out = (a & b) | (a & c) | (b & c);
            end
            OP_SUB: begin
                r     = a ^ b ^ c;
                c_out = (~a & b) | (~a & c) | (b & c);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: begin
                r     = 1'b0;
                c_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: WIDTH-bit operands processed LSB-first through a single
// alu_bit_cell, carry/borrow held in a flop between bits. start/busy/done
// handshake; result, cout and zero hold from done until the next accept.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [2:0]       op_q,     op_d;
    logic             c_q,      c_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             zero_q,   zero_d;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic cell_r;
    logic cell_c;
    logic accept;

    alu_bit_cell u_cell (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (c_q),
        .op    (op_q),
        .r     (cell_r),
        .c_out (cell_c)
    );

    // A new request is taken whenever no bits are in flight (IDLE or DONE).
    assign accept = start && (state_q != SHIFT);

    // Next-state and datapath: load on accept, shift one bit per SHIFT cycle.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        c_d      = c_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                c_d      = cell_c;
                result_d = {cell_r, result_q[WIDTH-1:1]};
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = cell_c;
                    zero_d  = (result_d == '0);
`ifdef SERIAL_ALU_OVF_EN
                    // Carry into the MSB xor carry out of it.
                    ovf_d   = is_arith(op_q) ? (c_q ^ cell_c) : 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = SHIFT;
            a_sh_d  = a;
            b_sh_d  = b;
            op_d    = op;
            c_d     = is_arith(op) ? cin : 1'b0;
            idx_d   = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8): directed test-plan cases,
// back-to-back and busy-ignore handshakes, mid-operation reset, and random
// operations checked against an arithmetic reference model.
module tb_serial_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, cout, result} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c);
        int ux, uy, sx, sy, u, s;
        logic [W-1:0] r;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        r = '0; co = 1'b0; ov = 1'b0;
        case (o)
            3'd0: begin
                u = ux + uy + int'(c); s = sx + sy + int'(c);
                r = W'(u); co = (u > 255); ov = (s > 127) || (s < -128);
            end
            3'd1: begin
                u = ux - uy - int'(c); s = sx - sy - int'(c);
                r = W'(u); co = (u < 0); ov = (s > 127) || (s < -128);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            default: r = '0;
        endcase
        return {ov, co, r};
    endfunction

    // Caller is at a negedge. Drives one accept, optionally pokes start while
    // busy, then waits (bounded) for done and checks latency and outputs.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c, input bit poke);
        logic [W+1:0] exp;
        int lat;
        exp = model(o, x, y, c);
        start = 1'b1; op = o; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 3) begin
                start = 1'b1; op = 3'd1; a = ~x; b = ~y; cin = ~c;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(W));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(exp[W-1:0]));
        check({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        check({tag, ".zero"}, 32'(zero), 32'(exp[W-1:0] == '0));
`ifdef SERIAL_ALU_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(exp[W+1]));
`endif
        $display("op=%0d a=%02h b=%02h cin=%0d -> result=%02h cout=%0d zero=%0d lat=%0d",
                 o, x, y, c, result, cout, zero, lat);
    endtask

    initial begin
        logic [W-1:0] held;
        int seen;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed test-plan cases, with explicit expected constants too.
        run_op("add5a3c", 3'd0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        check("add5a3c.const", 32'(result), 32'h96);
        @(negedge clk);
        run_op("addff01", 3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("addff01.const", 32'({cout, zero, result}), 32'h300);
`ifdef SERIAL_ALU_OVF_EN
        @(negedge clk);
        run_op("add7f01", 3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        check("add7f01.const", 32'({ovf, result}), 32'h180);
`endif
        @(negedge clk);
        run_op("sub1020", 3'd1, 8'h10, 8'h20, 1'b0, 1'b0);
        check("sub1020.const", 32'({cout, result}), 32'h1F0);
        run_op("sub2010", 3'd1, 8'h20, 8'h10, 1'b1, 1'b0);   // back-to-back from DONE
        check("sub2010.const", 32'({cout, result}), 32'h00F);
        @(negedge clk);
        run_op("and", 3'd2, 8'hF0, 8'h3C, 1'b1, 1'b0);
        check("and.const", 32'({cout, result}), 32'h030);
        run_op("or", 3'd3, 8'hF0, 8'h3C, 1'b1, 1'b0);
        check("or.const", 32'({cout, result}), 32'h0FC);
        run_op("xor", 3'd4, 8'hF0, 8'h3C, 1'b1, 1'b0);
        check("xor.const", 32'({cout, result}), 32'h0CC);
        run_op("rsvd7", 3'd7, 8'hF0, 8'h3C, 1'b1, 1'b0);
        check("rsvd7.const", 32'({cout, zero, result}), 32'h100);

        // Start pulsed while busy is ignored.
        @(negedge clk);
        run_op("busyign", 3'd0, 8'h5A, 8'h3C, 1'b0, 1'b1);
        check("busyign.const", 32'(result), 32'h96);

        // Result holds while idle.
        held = result;
        repeat (3) @(negedge clk);
        check("hold.done", 32'(done), 32'd0);
        check("hold.result", 32'(result), 32'(held));

        // Reset for one cycle mid-SHIFT.
        start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.result", 32'(result), 32'd0);
        check("midrst.cout", 32'(cout), 32'd0);
        check("midrst.zero", 32'(zero), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst.no_done", 32'(seen), 32'd0);

        // Random operations, with random idle gaps and back-to-back accepts.
        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), W'($urandom),
                   W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
